// File: rtl/trace_player.sv
// trace_player: replays a stored trace of timestamped input events into a
// monitor's input_N / new_input_N ports, honouring ready backpressure.
// Optional feature macro: TRACE_PLAYER_LOOP_EN adds a 'loop' input that
// restarts the trace after the last event instead of finishing.
//
// state  | meaning
// IDLE   | waiting for start; event memory may be written
// WAIT   | counting down the idle cycles before event idx, then waiting for ready
// FIRE   | strobing event idx onto the monitor ports for one cycle
// FIN    | one-cycle done pulse, then back to IDLE (or next pass when looping)
module trace_player #(
   parameter int NUM_IN  = 1,
   parameter int DATA_W  = 64,
   parameter int DELAY_W = 32,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DELAY_W-1:0]       wr_delay,
   input  logic [NUM_IN-1:0]        wr_mask,
   input  logic [NUM_IN*DATA_W-1:0] wr_data,
   output logic                     wr_err,
   input  logic                     start,
   input  logic [ADDR_W:0]          num_events,
   input  logic                     ready,
`ifdef TRACE_PLAYER_LOOP_EN
   input  logic                     loop,
`endif
   output logic [NUM_IN*DATA_W-1:0] input_data,
   output logic [NUM_IN-1:0]        new_input,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              stall_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE, S_FIN} state_t;

   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   logic [DELAY_W-1:0]       mem_delay [DEPTH];
   logic [NUM_IN-1:0]        mem_mask  [DEPTH];
   logic [NUM_IN*DATA_W-1:0] mem_data  [DEPTH];

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        idx_q, idx_d;
   logic [DELAY_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_W:0]          num_q, num_d;
   logic [15:0]              stall_q, stall_d;
   logic [NUM_IN-1:0]        new_input_q, new_input_d;
   logic [NUM_IN*DATA_W-1:0] input_data_q, input_data_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     wr_err_q, wr_err_d;

   logic                     addr_ok;
   logic                     wr_ok;
   logic                     out_en;
   logic                     is_last;
   logic [ADDR_W-1:0]        idx_nxt;
   logic [ADDR_W:0]          num_clamped;
   logic [DELAY_W-1:0]       rd0_delay;
   logic [NUM_IN*DATA_W-1:0] fire_data;

   // Out-of-range addresses only exist when DEPTH is not a power of two.
   generate
      if ((2 ** ADDR_W) == DEPTH) begin : g_addr_full
         assign addr_ok = 1'b1;
      end else begin : g_addr_part
         assign addr_ok = (int'(wr_addr) < DEPTH);
      end
   endgenerate

   // Loader writes are only honoured while playback is not running.
   assign wr_ok       = en & wr_en & ~busy & addr_ok;
   assign idx_nxt     = idx_q + ADDR_W'(1);
   assign is_last     = ({1'b0, idx_q} == (num_q - (ADDR_W+1)'(1)));
   assign num_clamped = (num_events > DEPTH_L) ? DEPTH_L : num_events;
   // A write to entry 0 in the same cycle as start must be seen by the start.
   assign rd0_delay   = (wr_ok && (wr_addr == '0)) ? wr_delay : mem_delay[0];

   // Strobes and pulses vanish at once under reset or a disabled clock enable.
   assign out_en     = en & ~rst;
   assign new_input  = new_input_q & {NUM_IN{out_en}};
   assign input_data = out_en ? input_data_q : '0;
   assign done       = done_q & out_en;
   assign wr_err     = wr_err_q & out_en;
   assign stall_cnt  = stall_q;
`ifdef TRACE_PLAYER_LOOP_EN
   assign busy       = busy_q | ((state_q == S_FIN) & loop);
`else
   assign busy       = busy_q;
`endif

   // Event memory: not reset, so a trace survives rst.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_delay[wr_addr] <= wr_delay;
         mem_mask[wr_addr]  <= wr_mask;
         mem_data[wr_addr]  <= wr_data;
      end
   end

   // Channel values of the current event with unflagged channels zeroed.
   always_comb begin
      fire_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (mem_mask[idx_q][i]) begin
            fire_data[i*DATA_W +: DATA_W] = mem_data[idx_q][i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and registered-output logic of the playback sequencer.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      num_d        = num_q;
      stall_d      = stall_q;
      busy_d       = busy_q;
      new_input_d  = '0;
      input_data_d = '0;
      done_d       = 1'b0;
      wr_err_d     = wr_en & ~(~busy & addr_ok);
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               stall_d = '0;
               if (num_clamped == '0) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = '0;
                  cnt_d   = rd0_delay;
                  num_d   = num_clamped;
                  busy_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - DELAY_W'(1);
            end else if (ready) begin
               new_input_d  = mem_mask[idx_q];
               input_data_d = fire_data;
               state_d      = S_FIRE;
            end else if (stall_q != 16'hFFFF) begin
               stall_d = stall_q + 16'd1;
            end
         end
         S_FIRE: begin
            if (is_last) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_FIN;
            end else begin
               idx_d   = idx_nxt;
               cnt_d   = mem_delay[idx_nxt];
               state_d = S_WAIT;
            end
         end
         default: begin
`ifdef TRACE_PLAYER_LOOP_EN
            if (loop) begin
               idx_d   = '0;
               cnt_d   = rd0_delay;
               busy_d  = 1'b1;
               state_d = S_WAIT;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
`else
            busy_d  = 1'b0;
            state_d = S_IDLE;
`endif
         end
      endcase
   end

   // Sequencer registers: synchronous reset, frozen while en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         num_q        <= '0;
         stall_q      <= '0;
         busy_q       <= 1'b0;
         new_input_q  <= '0;
         input_data_q <= '0;
         done_q       <= 1'b0;
         wr_err_q     <= 1'b0;
      end else if (en) begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         num_q        <= num_d;
         stall_q      <= stall_d;
         busy_q       <= busy_d;
         new_input_q  <= new_input_d;
         input_data_q <= input_data_d;
         done_q       <= done_d;
         wr_err_q     <= wr_err_d;
      end
   end

endmodule

// File: tb/tb_trace_player.sv
// Bench for trace_player (NUM_IN=2): directed steps, expected strobes and
// done pulses queued with their cycle numbers and popped by a monitor.
module tb_trace_player;

   localparam int NUM_IN = 2;
   localparam int DATA_W = 64;
   localparam int DELAY_W = 32;
   localparam int DEPTH = 16;
   localparam int ADDR_W = 4;
   localparam logic [63:0] NEG5 = 64'hFFFF_FFFF_FFFF_FFFB;

   logic                     clk = 1'b0;
   logic                     rst, en, wr_en, start, ready;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DELAY_W-1:0]       wr_delay;
   logic [NUM_IN-1:0]        wr_mask;
   logic [NUM_IN*DATA_W-1:0] wr_data;
   logic                     wr_err, busy, done;
   logic [ADDR_W:0]          num_events;
   logic [NUM_IN*DATA_W-1:0] input_data;
   logic [NUM_IN-1:0]        new_input;
   logic [15:0]              stall_cnt;
`ifdef TRACE_PLAYER_LOOP_EN
   logic                     loop;
`endif

   typedef struct {
      int          cyc;
      logic [1:0]  mask;
      logic [127:0] data;
   } ev_t;

   ev_t ev_q[$];
   int  done_q[$];
   ev_t mon_e;
   int  mon_d;
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;
   bit  mon_on = 1'b0;
   int  t0;

   trace_player #(
      .NUM_IN(NUM_IN), .DATA_W(DATA_W), .DELAY_W(DELAY_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_delay(wr_delay), .wr_mask(wr_mask),
      .wr_data(wr_data), .wr_err(wr_err),
      .start(start), .num_events(num_events), .ready(ready),
`ifdef TRACE_PLAYER_LOOP_EN
      .loop(loop),
`endif
      .input_data(input_data), .new_input(new_input),
      .busy(busy), .done(done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] m,
                     input logic [63:0] d1, input logic [63:0] d0);
      wr_en = 1'b1; wr_addr = a; wr_delay = d; wr_mask = m; wr_data = {d1, d0};
      tick();
      wr_en = 1'b0;
   endtask

   task automatic go(input logic [4:0] n);
      num_events = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_ev(input int c, input logic [1:0] m, input logic [63:0] d1,
                          input logic [63:0] d0);
      ev_t e;
      e.cyc  = c;
      e.mask = m;
      e.data = {(m[1] ? d1 : 64'd0), (m[0] ? d0 : 64'd0)};
      ev_q.push_back(e);
   endtask

   task automatic push_trace3(input int base);
      push_ev(base + 2, 2'b01, 64'd0, 64'd1);
      push_ev(base + 7, 2'b01, 64'd0, 64'd2);
      push_ev(base + 9, 2'b01, 64'd0, NEG5);
      done_q.push_back(base + 10);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((ev_q.size() != 0 || done_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("events_left", ev_q.size(), 0);
      check("dones_left", done_q.size(), 0);
      tick();
      tick();
   endtask

   // Monitor: every strobe and done pulse must match the head of its queue.
   always @(negedge clk) begin
      if (mon_on) begin
         if (new_input !== 2'b00) begin
            if (ev_q.size() == 0) begin
               check("unexpected_strobe", {126'd0, new_input}, 128'd0);
            end else begin
               mon_e = ev_q.pop_front();
               check("fire_cycle", cyc, mon_e.cyc);
               check("fire_mask", {126'd0, new_input}, {126'd0, mon_e.mask});
               check("fire_data", input_data, mon_e.data);
            end
         end else if (input_data !== '0) begin
            check("idle_data", input_data, 128'd0);
         end
         if (done !== 1'b0) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", {127'd0, done}, 128'd0);
            end else begin
               mon_d = done_q.pop_front();
               check("done_cycle", cyc, mon_d);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_delay = '0; wr_mask = '0;
      wr_data = '0; start = 1'b0; num_events = '0; ready = 1'b1;
`ifdef TRACE_PLAYER_LOOP_EN
      loop = 1'b0;
`endif
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_new_input", new_input, 0);
      check("rst_input_data", input_data, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_wr_err", wr_err, 0);
      mon_on = 1'b1;

      wr(4'd0, 32'd0, 2'b01, 64'd0, 64'd1);
      wr(4'd1, 32'd3, 2'b01, 64'd0, 64'd2);
      wr(4'd2, 32'd0, 2'b01, 64'd0, NEG5);

      // Basic three-event replay with ready held high.
      t0 = cyc; push_trace3(t0);
      go(5'd3);
      check("busy_after_start", busy, 1);
      drain(40);
      check("stall_basic", stall_cnt, 0);

      // Write while busy is dropped with a wr_err pulse; memory unchanged.
      t0 = cyc; push_trace3(t0);
      go(5'd3);
      wr(4'd1, 32'd0, 2'b11, 64'd99, 64'd99);
      check("wr_err_pulse", wr_err, 1);
      tick();
      check("wr_err_low", wr_err, 0);
      drain(40);
      t0 = cyc; push_trace3(t0);
      go(5'd3);
      drain(40);

      // Backpressure: ready low for 4 cycles when event 1 is due.
      t0 = cyc;
      push_ev(t0 + 2, 2'b01, 64'd0, 64'd1);
      push_ev(t0 + 11, 2'b01, 64'd0, 64'd2);
      push_ev(t0 + 13, 2'b01, 64'd0, NEG5);
      done_q.push_back(t0 + 14);
      go(5'd3);
      while (cyc < t0 + 6) tick();
      ready = 1'b0;
      repeat (4) tick();
      ready = 1'b1;
      drain(40);
      check("stall_cnt_4", stall_cnt, 4);

      // Clock enable low for 5 cycles mid-WAIT delays event 1 by 5.
      t0 = cyc;
      push_ev(t0 + 2, 2'b01, 64'd0, 64'd1);
      push_ev(t0 + 12, 2'b01, 64'd0, 64'd2);
      push_ev(t0 + 14, 2'b01, 64'd0, NEG5);
      done_q.push_back(t0 + 15);
      go(5'd3);
      check("stall_cleared", stall_cnt, 0);
      while (cyc < t0 + 4) tick();
      en = 1'b0;
      repeat (5) tick();
      en = 1'b1;
      drain(40);

      // Reset after event 0 fires: no done, no further strobes.
      t0 = cyc;
      push_ev(t0 + 2, 2'b01, 64'd0, 64'd1);
      go(5'd3);
      while (cyc < t0 + 3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", busy, 0);
      repeat (15) tick();
      check("rst_mid_events", ev_q.size(), 0);
      check("rst_mid_dones", done_q.size(), 0);
      t0 = cyc; push_trace3(t0);
      go(5'd3);
      drain(40);

      // num_events = 0 finishes immediately with no strobe.
      t0 = cyc;
      done_q.push_back(t0 + 1);
      go(5'd0);
      check("zero_busy", busy, 0);
      drain(10);

      // Two channels, only channel 1 flagged.
      wr(4'd0, 32'd1, 2'b10, 64'd7, 64'd9);
      t0 = cyc;
      push_ev(t0 + 3, 2'b10, 64'd7, 64'd9);
      done_q.push_back(t0 + 4);
      go(5'd1);
      drain(20);

      // Write to entry 0 in the same cycle as start is seen by the replay.
      t0 = cyc;
      push_ev(t0 + 2, 2'b01, 64'd0, 64'd42);
      done_q.push_back(t0 + 3);
      wr_en = 1'b1; wr_addr = 4'd0; wr_delay = 32'd0; wr_mask = 2'b01;
      wr_data = {64'd0, 64'd42};
      num_events = 5'd1; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      drain(20);

`ifdef TRACE_PLAYER_LOOP_EN
      // Looping: two passes give two done pulses.
      t0 = cyc;
      push_ev(t0 + 2, 2'b01, 64'd0, 64'd42);
      push_ev(t0 + 5, 2'b01, 64'd0, 64'd42);
      done_q.push_back(t0 + 3);
      done_q.push_back(t0 + 6);
      loop = 1'b1;
      go(5'd1);
      while (cyc < t0 + 4) tick();
      loop = 1'b0;
      drain(20);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
